// File: rtl/vreg_wb_arbiter.sv
// Vector register-file writeback arbiter: round-robin between ALU and load
// unit, one registered write per cycle, with pending-write scoreboard and hazard probe.
module vreg_wb_arbiter #(
  parameter int unsigned REGSIZE       = 16,
  parameter int unsigned VECTORSPERREG = 16,
  parameter int unsigned DATAWIDTH     = 8,
  parameter int unsigned REGSIZEINT    = 5
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 issue_valid,
  input  logic [REGSIZEINT-1:0]                issue_rd,
  input  logic [REGSIZEINT-1:0]                chk_ra1,
  input  logic [REGSIZEINT-1:0]                chk_ra2,
  input  logic [REGSIZEINT-1:0]                chk_rd,
  output logic                                 hazard,
  input  logic                                 alu_valid,
  input  logic                                 mem_valid,
  input  logic [REGSIZEINT-1:0]                alu_rd,
  input  logic [REGSIZEINT-1:0]                mem_rd,
  input  logic [VECTORSPERREG*DATAWIDTH-1:0]   alu_wd,
  input  logic [VECTORSPERREG*DATAWIDTH-1:0]   mem_wd,
  output logic                                 alu_ready,
  output logic                                 mem_ready,
  output logic                                 we3,
  output logic [REGSIZEINT-1:0]                ra3,
  output logic [VECTORSPERREG*DATAWIDTH-1:0]   wd3,
  output logic [REGSIZE-1:0]                   pending,
  output logic                                 addr_err
);

  localparam int unsigned        WDW       = VECTORSPERREG * DATAWIDTH;
  localparam logic [REGSIZEINT:0] REG_LIMIT = (REGSIZEINT+1)'(REGSIZE);
  localparam logic               GRANT_ALU = 1'b0;
  localparam logic               GRANT_MEM = 1'b1;

  logic                  r_we3;
  logic [REGSIZEINT-1:0] r_ra3;
  logic [WDW-1:0]        r_wd3;
  logic [REGSIZE-1:0]    r_pending;
  logic                  r_addr_err;
  logic                  r_last_grant;

  logic                  w_alu_win;
  logic                  w_mem_win;
  logic                  w_acc;
  logic [REGSIZEINT-1:0] w_rd;
  logic [WDW-1:0]        w_wd;
  logic                  w_rd_ok;
  logic                  w_issue_ok;
  logic [REGSIZE-1:0]    w_set;
  logic [REGSIZE-1:0]    w_clr;
  logic                  w_err;

  // Out-of-range addresses simply match no scoreboard bit.
  function automatic logic f_pend(input logic [REGSIZE-1:0]    p,
                                  input logic [REGSIZEINT-1:0] a);
    logic r;
    r = 1'b0;
    for (int i = 0; i < int'(REGSIZE); i++) begin
      if (a == REGSIZEINT'(i)) r = p[i];
    end
    return r;
  endfunction

  // Round-robin: on contention the requester not granted last time wins.
  always_comb begin
    w_alu_win = alu_valid & (~mem_valid | (r_last_grant == GRANT_MEM));
    w_mem_win = mem_valid & (~alu_valid | (r_last_grant == GRANT_ALU));
    w_acc     = w_alu_win | w_mem_win;
    w_rd      = w_alu_win ? alu_rd : mem_rd;
    w_wd      = w_alu_win ? alu_wd : mem_wd;
  end

  always_comb begin
    w_rd_ok    = {1'b0, w_rd} < REG_LIMIT;
    w_issue_ok = {1'b0, issue_rd} < REG_LIMIT;
    w_err      = (issue_valid & ~w_issue_ok) | (w_acc & ~w_rd_ok);
    w_set      = '0;
    w_clr      = '0;
    for (int i = 0; i < int'(REGSIZE); i++) begin
      w_set[i] = issue_valid & (issue_rd == REGSIZEINT'(i));
      w_clr[i] = w_acc & (w_rd == REGSIZEINT'(i));
    end
  end

  always_comb begin
    hazard = f_pend(r_pending, chk_ra1) | f_pend(r_pending, chk_ra2) |
             f_pend(r_pending, chk_rd);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we3        <= 1'b0;
      r_ra3        <= '0;
      r_wd3        <= '0;
      r_pending    <= '0;
      r_addr_err   <= 1'b0;
      r_last_grant <= GRANT_MEM;
    end else begin
      r_we3 <= w_acc & w_rd_ok;
      if (w_acc & w_rd_ok) begin
        r_ra3 <= w_rd;
        r_wd3 <= w_wd;
      end
      if (w_acc) r_last_grant <= w_mem_win ? GRANT_MEM : GRANT_ALU;
      // Set after clear: a new producer outranks a retiring one.
      r_pending <= (r_pending & ~w_clr) | w_set;
      if (w_err) r_addr_err <= 1'b1;
    end
  end

  assign alu_ready = w_alu_win;
  assign mem_ready = w_mem_win;
  assign we3       = r_we3;
  assign ra3       = r_ra3;
  assign wd3       = r_wd3;
  assign pending   = r_pending;
  assign addr_err  = r_addr_err;

endmodule

// File: tb/tb_vreg_wb_arbiter.sv
// Directed self-checking bench for vreg_wb_arbiter (default parameters).
module tb_vreg_wb_arbiter;

  localparam int unsigned RW  = 5;
  localparam int unsigned WDW = 128;

  logic           clk;
  logic           rst_n;
  logic           issue_valid;
  logic [RW-1:0]  issue_rd;
  logic [RW-1:0]  chk_ra1, chk_ra2, chk_rd;
  logic           hazard;
  logic           alu_valid, mem_valid;
  logic [RW-1:0]  alu_rd, mem_rd;
  logic [WDW-1:0] alu_wd, mem_wd;
  logic           alu_ready, mem_ready;
  logic           we3;
  logic [RW-1:0]  ra3;
  logic [WDW-1:0] wd3;
  logic [15:0]    pending;
  logic           addr_err;

  int n_total;
  int n_bad;

  vreg_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .chk_ra1(chk_ra1), .chk_ra2(chk_ra2), .chk_rd(chk_rd), .hazard(hazard),
    .alu_valid(alu_valid), .mem_valid(mem_valid),
    .alu_rd(alu_rd), .mem_rd(mem_rd), .alu_wd(alu_wd), .mem_wd(mem_wd),
    .alu_ready(alu_ready), .mem_ready(mem_ready),
    .we3(we3), .ra3(ra3), .wd3(wd3), .pending(pending), .addr_err(addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_total = 0; n_bad = 0;
    rst_n = 1'b0; issue_valid = 1'b0; issue_rd = '0;
    chk_ra1 = '0; chk_ra2 = '0; chk_rd = '0;
    alu_valid = 1'b0; mem_valid = 1'b0; alu_rd = '0; mem_rd = '0;
    alu_wd = '0; mem_wd = '0;

    #3;
    check_eq("rst_we3", 128'(we3), 128'(0));
    check_eq("rst_ra3", 128'(ra3), 128'(0));
    check_eq("rst_wd3", wd3, 128'(0));
    check_eq("rst_pending", 128'(pending), 128'(0));
    check_eq("rst_addr_err", 128'(addr_err), 128'(0));
    check_eq("rst_hazard", 128'(hazard), 128'(0));
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step();

    // Basic issue -> writeback of register 3
    issue_valid = 1'b1; issue_rd = 5'd3; chk_rd = 5'd3;
    step();
    issue_valid = 1'b0;
    check_eq("p3_set", 128'(pending), 128'(16'h0008));
    check_eq("p3_hazard", 128'(hazard), 128'(1));
    alu_valid = 1'b1; alu_rd = 5'd3; alu_wd = {16{8'h5A}};
    #1;
    check_eq("wb3_alu_ready", 128'(alu_ready), 128'(1));
    check_eq("wb3_mem_ready", 128'(mem_ready), 128'(0));
    step();
    alu_valid = 1'b0;
    check_eq("wb3_we3", 128'(we3), 128'(1));
    check_eq("wb3_ra3", 128'(ra3), 128'(3));
    check_eq("wb3_wd3", wd3, {16{8'h5A}});
    check_eq("wb3_pending", 128'(pending), 128'(0));
    check_eq("wb3_hazard", 128'(hazard), 128'(0));
    step();
    check_eq("idle_we3", 128'(we3), 128'(0));
    check_eq("idle_ra3_hold", 128'(ra3), 128'(3));

    // Fresh reset so ALU wins the first contention
    @(negedge clk) rst_n = 1'b0;
    #1 rst_n = 1'b1;
    step();
    chk_rd = '0;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_wd = {16{8'h11}};
    mem_valid = 1'b1; mem_rd = 5'd2; mem_wd = {16{8'h22}};
    for (int k = 0; k < 4; k++) begin
      #1;
      check_eq("rr_alu_ready", 128'(alu_ready), 128'((k % 2) == 0));
      check_eq("rr_mem_ready", 128'(mem_ready), 128'((k % 2) == 1));
      step();
      check_eq("rr_we3", 128'(we3), 128'(1));
      check_eq("rr_ra3", 128'(ra3), ((k % 2) == 0) ? 128'(1) : 128'(2));
      check_eq("rr_wd3", wd3, ((k % 2) == 0) ? {16{8'h11}} : {16{8'h22}});
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    step();
    check_eq("rr_idle_we3", 128'(we3), 128'(0));

    // Hazard on register 7
    issue_valid = 1'b1; issue_rd = 5'd7;
    step();
    issue_valid = 1'b0; chk_ra2 = 5'd7;
    #1;
    check_eq("h7_hazard", 128'(hazard), 128'(1));
    mem_valid = 1'b1; mem_rd = 5'd7; mem_wd = {16{8'h33}};
    #1;
    check_eq("h7_mem_ready", 128'(mem_ready), 128'(1));
    step();
    mem_valid = 1'b0;
    check_eq("h7_cleared_hazard", 128'(hazard), 128'(0));
    check_eq("h7_cleared_pending", 128'(pending), 128'(0));
    issue_valid = 1'b1; issue_rd = 5'd7;
    step();
    check_eq("h7_reissue", 128'(pending), 128'(16'h0080));
    alu_valid = 1'b1; alu_rd = 5'd7; alu_wd = {16{8'h44}};
    #1;
    check_eq("same_alu_ready", 128'(alu_ready), 128'(1));
    step();
    issue_valid = 1'b0; alu_valid = 1'b0;
    check_eq("same_pending", 128'(pending), 128'(16'h0080));
    check_eq("same_hazard", 128'(hazard), 128'(1));
    check_eq("same_we3", 128'(we3), 128'(1));
    check_eq("same_ra3", 128'(ra3), 128'(7));

    // Writeback to a register with nothing pending
    alu_valid = 1'b1; alu_rd = 5'd9; alu_wd = {16{8'h55}};
    step();
    alu_valid = 1'b0;
    check_eq("np_pending", 128'(pending), 128'(16'h0080));
    check_eq("np_we3", 128'(we3), 128'(1));
    check_eq("np_ra3", 128'(ra3), 128'(9));

    // Out-of-range probes and writeback
    chk_ra1 = 5'd20; chk_ra2 = 5'd20; chk_rd = 5'd20;
    #1;
    check_eq("oor_hazard", 128'(hazard), 128'(0));
    check_eq("oor_err_before", 128'(addr_err), 128'(0));
    mem_valid = 1'b1; mem_rd = 5'd20; mem_wd = {16{8'h66}};
    #1;
    check_eq("oor_mem_ready", 128'(mem_ready), 128'(1));
    step();
    mem_valid = 1'b0;
    check_eq("oor_we3", 128'(we3), 128'(0));
    check_eq("oor_addr_err", 128'(addr_err), 128'(1));
    check_eq("oor_pending", 128'(pending), 128'(16'h0080));
    repeat (3) step();
    check_eq("oor_sticky", 128'(addr_err), 128'(1));
    // Pointer moved to MEM on the out-of-range grant, so ALU wins now
    alu_valid = 1'b1; mem_valid = 1'b1; alu_rd = 5'd1; mem_rd = 5'd2;
    #1;
    check_eq("oor_rr_alu", 128'(alu_ready), 128'(1));
    check_eq("oor_rr_mem", 128'(mem_ready), 128'(0));
    alu_valid = 1'b0; mem_valid = 1'b0;
    chk_ra1 = '0; chk_ra2 = '0; chk_rd = '0;

    // Async reset while a write is in flight
    for (int r = 0; r < 8; r++) begin
      issue_valid = 1'b1; issue_rd = RW'(r);
      if (r == 7) begin
        alu_valid = 1'b1; alu_rd = 5'd8; alu_wd = {16{8'h77}};
      end
      step();
    end
    issue_valid = 1'b0; alu_valid = 1'b0;
    check_eq("ar_pending_pre", 128'(pending), 128'(16'h00FF));
    check_eq("ar_we3_pre", 128'(we3), 128'(1));
    check_eq("ar_ra3_pre", 128'(ra3), 128'(8));
    #2 rst_n = 1'b0;
    #1;
    check_eq("ar_we3", 128'(we3), 128'(0));
    check_eq("ar_pending", 128'(pending), 128'(0));
    check_eq("ar_addr_err", 128'(addr_err), 128'(0));
    check_eq("ar_ra3", 128'(ra3), 128'(0));
    @(negedge clk) rst_n = 1'b1;
    step();

    // Out-of-range issue flags error, touches no bit
    issue_valid = 1'b1; issue_rd = 5'd20;
    step();
    issue_valid = 1'b0;
    check_eq("iss_oor_err", 128'(addr_err), 128'(1));
    check_eq("iss_oor_pending", 128'(pending), 128'(0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/vreg_wb_arbiter.md
VREG_WB_ARBITER -- requirements
Module: vreg_wb_arbiter

Interface
REQ-001 SHALL have parameter REGSIZE, default 16, number of vector registers.
REQ-002 SHALL have parameter VECTORSPERREG, default 16, lanes per vector register.
REQ-003 SHALL have parameter DATAWIDTH, default 8, bits per lane.
REQ-004 SHALL have parameter REGSIZEINT, default 5, register address width.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port issue_valid  input  1  instruction issued with vector destination.
REQ-008 SHALL have port issue_rd  input  REGSIZEINT  destination of issued instruction.
REQ-009 SHALL have port chk_ra1, chk_ra2, chk_rd  input  REGSIZEINT each  sources/destination probed for hazard.
REQ-010 SHALL have port hazard  output  1  any probed register pending.
REQ-011 SHALL have port alu_valid, mem_valid  input  1 each  writeback request from ALU / load unit.
REQ-012 SHALL have port alu_rd, mem_rd  input  REGSIZEINT each  requested destination.
REQ-013 SHALL have port alu_wd, mem_wd  input  VECTORSPERREG x DATAWIDTH each  write data.
REQ-014 SHALL have port alu_ready, mem_ready  output  1 each  request accepted this cycle.
REQ-015 SHALL have port we3  output  1  register-file write enable (registered).
REQ-016 SHALL have port ra3  output  REGSIZEINT  register-file write address (registered).
REQ-017 SHALL have port wd3  output  VECTORSPERREG x DATAWIDTH  register-file write data (registered).
REQ-018 SHALL have port pending  output  REGSIZE  per-register pending-write bits.
REQ-019 SHALL have port addr_err  output  1  sticky out-of-range address flag.

Function
REQ-020 SHALL accept at most one writeback per cycle; transfer occurs when valid and ready are both high at posedge.
REQ-021 SHALL drive ready combinationally: only one valid -> that requester ready; both valid -> round-robin winner ready; none valid -> both ready low.
REQ-022 SHALL keep a 1-bit last-grant register, updated only on an accepted transfer; on contention the requester not last granted wins.
REQ-023 SHALL, on acceptance at posedge N, drive we3=1 with ra3/wd3 of the winner during cycle N..N+1 so the register file writes at the following negedge; latency one cycle.
REQ-024 SHALL drive we3=0 in any cycle following no acceptance; ra3/wd3 hold their last values.
REQ-025 SHALL set pending[issue_rd] at posedge when issue_valid=1 and issue_rd<REGSIZE.
REQ-026 SHALL clear pending[rd] at the posedge where a writeback to rd<REGSIZE is accepted.
REQ-027 SHALL, when set and clear target the same register in one cycle, leave the bit set (new producer wins).
REQ-028 SHALL compute hazard combinationally = pending[chk_ra1] | pending[chk_ra2] | pending[chk_rd]; out-of-range probes contribute 0.
REQ-029 SHALL accept a writeback with rd>=REGSIZE normally (ready asserted, arbitration pointer updated) but not assert we3 for it.
REQ-030 SHALL set addr_err on any issue or accepted writeback with address >= REGSIZE; it stays set until reset.
REQ-031 SHALL not alter pending for writebacks whose register is not pending (no underflow, bit stays 0).

Reset
REQ-032 SHALL, while rst_n=0, force we3=0, ra3=0, wd3=0, pending=0, addr_err=0, last-grant=mem (ALU wins first contention), independent of clk.
REQ-033 SHALL, on reset asserted mid-operation, discard any in-flight write (we3 drops immediately) with no requester considered accepted after reset.

Verification
REQ-034 SHALL verify: issue_rd=3, then alu_valid rd=3 wd=all 0x5A -> alu_ready=1 same cycle; next cycle we3=1, ra3=3, wd3=0x5A lanes; pending[3] 1->0 at acceptance.
REQ-035 SHALL verify: alu_valid and mem_valid held high 4 cycles after reset -> grants ALU, MEM, ALU, MEM; we3 high all 4 following cycles.
REQ-036 SHALL verify: pending[7]=1, chk_ra2=7 -> hazard=1; writeback to 7 accepted -> hazard=0 from the next cycle; same-cycle issue_rd=7 and writeback rd=7 -> pending[7] stays 1.
REQ-037 SHALL verify: mem_valid rd=20 (REGSIZE=16) -> mem_ready=1, next cycle we3=0, addr_err=1 until rst_n low.
REQ-038 SHALL verify: rst_n low while we3=1 and pending=0x00FF -> we3=0 and pending=0 immediately, before next clk edge.
